// File: rtl/frame_row_scanout.sv
// Frame row scanout: snapshots a composed game board on request and streams
// it to the display driver one 10-bit row per valid/ready transfer.

package game_state_pkg;
    // Composed board, addressed as screen[x][y] with x 0..9 and y 0..19.
    typedef struct packed {
        logic [9:0][19:0] screen;
    } game_state_t;
endpackage

module frame_row_scanout
    import game_state_pkg::*;
#(
    parameter bit BOTTOM_FIRST = 1'b0,
    parameter int DROP_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  game_state_t           frame_i,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  row_valid_o,
    input  logic                  row_ready_i,
    output logic [9:0]            row_data_o,
    output logic [4:0]            row_idx_o,
    output logic                  sof_o,
    output logic                  eof_o,
    output logic                  frame_done_o,
    output logic [DROP_CNT_W-1:0] dropped_o
);

    localparam logic [4:0] FIRST_ROW = BOTTOM_FIRST ? 5'd19 : 5'd0;
    localparam logic [4:0] LAST_ROW  = BOTTOM_FIRST ? 5'd0  : 5'd19;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [4:0]              cnt_q, cnt_d;
    game_state_t             snap_q, snap_d;
    logic [DROP_CNT_W-1:0]   drop_q, drop_d;
    logic [9:0]              rowSel;

    // State, row counter, snapshot and drop counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            snap_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic: capture on start in IDLE, step rows on each transfer,
    // and count starts that arrive while a frame is still in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        drop_d  = drop_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    snap_d  = frame_i;
                    cnt_d   = FIRST_ROW;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (row_ready_i) begin
                    if (cnt_q == LAST_ROW) begin
                        state_d = DONE;
                    end else if (BOTTOM_FIRST) begin
                        cnt_d = cnt_q - 5'd1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (start_i && (state_q != IDLE) && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    // Gather one row of the snapshot: bit x comes from column x at the current y.
    always_comb begin
        rowSel = '0;
        for (int x = 0; x < 10; x++) begin
            rowSel[x] = snap_q.screen[x][cnt_q];
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign row_valid_o  = (state_q == STREAM);
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = (state_q == DONE);
    assign row_idx_o    = cnt_q;
    assign row_data_o   = row_valid_o ? rowSel : 10'd0;
    assign sof_o        = row_valid_o && (cnt_q == FIRST_ROW);
    assign eof_o        = row_valid_o && (cnt_q == LAST_ROW);
    assign dropped_o    = drop_q;

endmodule

// File: tb/tb_frame_row_scanout.sv
// Directed testbench for frame_row_scanout: top-first instance with default
// drop counter, and a bottom-first instance with a 2-bit drop counter.

module tb_frame_row_scanout;
    import game_state_pkg::*;

    logic clk = 1'b0;
    logic reset;

    game_state_t frame0, frame1;
    logic        start0, ready0, start1, ready1;
    logic        busy0, valid0, sof0, eof0, done0;
    logic        busy1, valid1, sof1, eof1, done1;
    logic [9:0]  data0, data1;
    logic [4:0]  idx0, idx1;
    logic [7:0]  drop0;
    logic [1:0]  drop1;

    int vectors = 0;
    int miscompares = 0;

    frame_row_scanout #(.BOTTOM_FIRST(1'b0), .DROP_CNT_W(8)) u0 (
        .clk(clk), .reset(reset), .frame_i(frame0), .start_i(start0),
        .busy_o(busy0), .row_valid_o(valid0), .row_ready_i(ready0),
        .row_data_o(data0), .row_idx_o(idx0), .sof_o(sof0), .eof_o(eof0),
        .frame_done_o(done0), .dropped_o(drop0)
    );

    frame_row_scanout #(.BOTTOM_FIRST(1'b1), .DROP_CNT_W(2)) u1 (
        .clk(clk), .reset(reset), .frame_i(frame1), .start_i(start1),
        .busy_o(busy1), .row_valid_o(valid1), .row_ready_i(ready1),
        .row_data_o(data1), .row_idx_o(idx1), .sof_o(sof1), .eof_o(eof1),
        .frame_done_o(done1), .dropped_o(drop1)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] rowVal(input int y);
        return 10'((y * 41 + 3) & 'h3ff);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd);
        start0 = st;
        ready0 = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic loadPatternFrame();
        logic [9:0] v;
        frame0 = '0;
        for (int y = 0; y < 20; y++) begin
            v = rowVal(y);
            for (int x = 0; x < 10; x++) begin
                frame0.screen[x][y] = v[x];
            end
        end
    endtask

    initial begin
        int expRow;
        int cyc;
        int xfers;
        logic rd;

        reset = 1'b1;
        frame0 = '0; frame1 = '0;
        start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", valid0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_data", data0, 0);
        checkOutput("rst_idx", idx0, 0);
        checkOutput("rst_done", done0, 0);
        checkOutput("rst_drop", drop0, 0);
        checkOutput("rst_drop1", drop1, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full throughput, single set cell at x=3 y=5
        frame0 = '0;
        frame0.screen[3][5] = 1'b1;
        applyStimulus(1'b1, 1'b1);
        start0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checkOutput("ft_valid", valid0, 1);
            checkOutput("ft_idx", idx0, i);
            checkOutput("ft_data", data0, (i == 5) ? 10'b0000001000 : 10'd0);
            checkOutput("ft_sof", sof0, (i == 0));
            checkOutput("ft_eof", eof0, (i == 19));
            checkOutput("ft_nodone", done0, 0);
            applyStimulus(1'b0, 1'b1);
        end
        checkOutput("ft_done", done0, 1);
        checkOutput("ft_done_valid", valid0, 0);
        checkOutput("ft_done_busy", busy0, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("ft_idle_done", done0, 0);
        checkOutput("ft_idle_busy", busy0, 0);
        checkOutput("ft_idle_valid", valid0, 0);

        // Backpressure, snapshot isolation and busy starts
        loadPatternFrame();
        applyStimulus(1'b1, 1'b0);
        start0 = 1'b0;
        frame0 = '1;
        expRow = 0;
        cyc = 0;
        xfers = 0;
        while (expRow < 20 && cyc < 200) begin
            checkOutput("bp_valid", valid0, 1);
            checkOutput("bp_idx", idx0, expRow);
            checkOutput("bp_data", data0, rowVal(expRow));
            checkOutput("bp_sof", sof0, (expRow == 0));
            checkOutput("bp_eof", eof0, (expRow == 19));
            rd = ((cyc % 3) == 0);
            applyStimulus((cyc == 2 || cyc == 5 || cyc == 8), rd);
            if (rd) begin
                expRow++;
                xfers++;
            end
            cyc++;
        end
        start0 = 1'b0;
        ready0 = 1'b0;
        checkOutput("bp_budget", (cyc < 200), 1);
        checkOutput("bp_xfers", xfers, 20);
        checkOutput("bp_done", done0, 1);
        checkOutput("bp_dropped", drop0, 3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("bp_idle_busy", busy0, 0);

        // Bottom-first order and drop counter saturation
        frame1 = '0;
        frame1.screen[9][19] = 1'b1;
        start1 = 1'b1;
        ready1 = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("bf_valid", valid1, 1);
            checkOutput("bf_idx", idx1, 19 - i);
            checkOutput("bf_data", data1, (i == 0) ? 10'b1000000000 : 10'd0);
            checkOutput("bf_sof", sof1, (i == 0));
            checkOutput("bf_eof", eof1, (i == 19));
            start1 = (i < 5);
            @(posedge clk);
            #1;
        end
        start1 = 1'b0;
        checkOutput("bf_done", done1, 1);
        checkOutput("bf_drop_sat", drop1, 3);

        // Reset in the middle of a frame
        loadPatternFrame();
        applyStimulus(1'b1, 1'b1);
        start0 = 1'b0;
        repeat (7) applyStimulus(1'b0, 1'b1);
        checkOutput("mr_idx", idx0, 7);
        checkOutput("mr_data", data0, rowVal(7));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mr_valid", valid0, 0);
        checkOutput("mr_busy", busy0, 0);
        checkOutput("mr_data0", data0, 0);
        checkOutput("mr_idx0", idx0, 0);
        checkOutput("mr_sof", sof0, 0);
        checkOutput("mr_eof", eof0, 0);
        checkOutput("mr_done", done0, 0);
        checkOutput("mr_drop", drop0, 0);
        checkOutput("mr_drop1", drop1, 0);
        #3;
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1);
        checkOutput("mr_after_busy", busy0, 0);
        checkOutput("mr_after_valid", valid0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_row_scanout.md
Name: frame_row_scanout

Overview:
- Reader end of the composed-board path: snapshots a full game_state_pkg::game_state_t frame (locked board plus overlaid active piece) on request.
- Streams the snapshot out one 10-bit row per transfer over a valid/ready interface to the display/LED-matrix driver.
- Sits in the GAME_clk domain, downstream of the piece-overlay logic, and decouples frame composition from display timing.

Parameters:
- BOTTOM_FIRST, 0, 0: rows emitted y=0 upward to y=19; 1: rows emitted y=19 downward to y=0.
- DROP_CNT_W, 8, width of the saturating dropped-start counter.

Ports:
- clk  input  1  game clock.
- reset  input  1  asynchronous, active-high reset.
- frame_i  input  game_state_t  composed board; screen[x][y], x 0..9, y 0..19.
- start_i  input  1  single-cycle request to snapshot frame_i and stream it.
- busy_o  output  1  high from the cycle after an accepted start until frame_done_o deasserts.
- row_valid_o  output  1  row word available.
- row_ready_i  input  1  sink accepts the row.
- row_data_o  output  10  row_data_o[x] = snapshot.screen[x][row_idx_o].
- row_idx_o  output  5  y index of the current row.
- sof_o  output  1  high with the first row of a frame.
- eof_o  output  1  high with the last row of a frame.
- frame_done_o  output  1  one-cycle pulse after the last row is accepted.
- dropped_o  output  DROP_CNT_W  count of start_i pulses ignored while busy; saturates at all-ones.

Behaviour:
- Reset (async, any state, including mid-frame): FSM=IDLE. row_valid_o, sof_o, eof_o, frame_done_o, busy_o = 0. row_data_o = 0. row_idx_o = 0. dropped_o = 0. Snapshot register cleared. A partially sent frame is abandoned.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start_i=1 captures frame_i into the snapshot register that cycle.
  - Next state is STREAM.
  - Row counter loads 0 (BOTTOM_FIRST=0) or 19 (BOTTOM_FIRST=1).
- STREAM:
  - row_valid_o=1 continuously.
  - row_idx_o = row counter.
  - row_data_o is built from the snapshot only. Changes on frame_i after capture have no effect.
  - Transfer occurs when row_valid_o & row_ready_i.
  - Without a transfer, row_data_o, row_idx_o, sof_o and eof_o hold stable.
  - On a transfer of a non-last row, the counter steps by +1 (or -1 when BOTTOM_FIRST=1).
  - On a transfer of the last row (19, or 0 when BOTTOM_FIRST=1), next state is DONE.
  - sof_o = (counter == first row). eof_o = (counter == last row).
- DONE: frame_done_o=1 for exactly one cycle, row_valid_o=0, then IDLE.
- Latency:
  - First row_valid_o is asserted 1 cycle after the start_i cycle.
  - With row_ready_i held high, a frame occupies 20 consecutive valid cycles, then 1 DONE cycle.
  - Start to frame_done_o is 21 cycles.
  - The earliest next start_i is accepted in the cycle after DONE (IDLE).
- start_i while in STREAM or DONE is ignored (snapshot unchanged). dropped_o increments by 1, saturating at 2^DROP_CNT_W-1, with no wrap.
- start_i asserted for multiple cycles in IDLE: the first cycle is accepted, and later cycles count as drops.
- row_ready_i is ignored when row_valid_o=0. A ready without valid has no effect.
- All outputs are registered. There is no combinational path from row_ready_i or start_i to any output.

Test Plan:
- Reset mid-stream: start, accept 7 rows, assert reset -> all outputs 0 immediately (async). After release, FSM is IDLE and busy_o=0.
- Full-throughput frame: frame_i with only screen[3][5]=1, start_i, row_ready_i=1 ->
  - row_valid_o rows 0..19 on consecutive cycles.
  - row 5 data=10'b0000001000; all other rows 0.
  - sof_o on row 0, eof_o on row 19, frame_done_o at cycle 21.
- Backpressure: row_ready_i toggled 1,0,0,1,... -> row_data_o and row_idx_o stay stable during stalls. No row is skipped or duplicated, and exactly 20 transfers occur.
- Snapshot isolation: change frame_i to all-ones the cycle after start -> all streamed rows match the original frame.
- Busy starts: pulse start_i 3 times during STREAM -> dropped_o=3, frame unaffected. With DROP_CNT_W=2 and 5 drops -> dropped_o saturates at 3.
- BOTTOM_FIRST=1 with screen[9][19]=1 -> first row has idx 19, data 10'b1000000000, sof_o=1; eof_o on idx 0.
